fb_swap_ctrl: RTL and testbench

Scheduler for the double-buffered VGA frame memory. It decides which buffer the display path reads and which one the renderer writes, and it starts each render pass. It swaps buffers only on a frame boundary, and only after the renderer reports a complete frame, so the display never tears. It sits between the VGA timing generator, the renderer, and the frame-buffer module, whose buffer-select input it drives.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/fb_swap_ctrl_sat_counter.sv | 41 ++++
 rtl/fb_swap_ctrl.sv | 152 +++++++++++++++
 tb/tb_fb_swap_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer definitions: timing totals, swap FSM states, buffer-select encoding.
// Latency: none (declarations only).
// Backpressure: none.
package vga_pkg;

    // Default frame geometry, shared with the timing generator and frame buffer.
    localparam int unsigned VGA_H_TOTAL = 1056;
    localparam int unsigned VGA_V_TOTAL = 628;

    // Buffer-swap scheduler states.
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RENDER = 2'd1,
        READY  = 2'd2,
        SWAP   = 2'd3
    } fb_state_t;

    // disp_sel encoding: which buffer the display path reads.
    localparam logic DISP_A = 1'b0;  // display A, renderer writes B
    localparam logic DISP_B = 1'b1;  // display B, renderer writes A

endpackage

// File: rtl/fb_swap_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Latency: count updates on the clock edge after inc_i/clr_i.
// Backpressure: none; increments at the limit are absorbed silently.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise step up until the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffer swap scheduler: swaps display/render buffers only at end of frame after a finished render.
// Latency: all outputs registered; disp_sel/swap/render_start change on the edge after the eof cycle.
// Backpressure: en=0 holds a finished frame in READY; a missing render_done repeats the old frame and counts it late.
module fb_swap_ctrl
    import vga_pkg::*;
#(
    parameter int H_TOTAL    = VGA_H_TOTAL,
    parameter int V_TOTAL    = VGA_V_TOTAL,
    parameter int LATE_LIMIT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [10:0]      hcount,
    input  logic [10:0]      vcount,
    input  logic             render_done,
    output logic             disp_sel,
    output logic             render_start,
    output logic             swap,
    output logic [CNT_W-1:0] late_cnt,
    output logic             stall
);

    localparam logic [10:0]      H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0]      V_LAST   = 11'(V_TOTAL - 1);
    localparam int               LATE_MAX = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(LATE_LIMIT);
    localparam logic [CNT_W-1:0] STALL_PRE = CNT_W'(LATE_LIMIT - 1);

    fb_state_t        state_q, state_d;
    logic             disp_sel_q, disp_sel_d;
    logic             render_start_q, render_start_d;
    logic             swap_q, swap_d;
    logic             stall_q, stall_d;
    logic             late_inc;
    logic             consec_clr;
    logic [CNT_W-1:0] consec;
    logic             eof;

    // Last pixel of the last line; out-of-range counts simply never match.
    assign eof = (hcount == H_LAST) && (vcount == V_LAST);

    // Scheduler next-state and registered-output decode.
    always_comb begin
        state_d        = state_q;
        disp_sel_d     = disp_sel_q;
        render_start_d = 1'b0;
        swap_d         = 1'b0;
        late_inc       = 1'b0;
        consec_clr     = 1'b0;

        case (state_q)
            INIT: begin
                render_start_d = 1'b1;
                state_d        = RENDER;
            end
            RENDER: begin
                if (render_done) begin
                    // Done on the boundary itself is on time; with en=0 the frame waits in READY.
                    if (eof && en) begin
                        state_d = SWAP;
                    end else begin
                        state_d = READY;
                    end
                end else if (eof) begin
                    // Frame boundary passed without a new frame: front buffer repeats.
                    late_inc = 1'b1;
                end
            end
            READY: begin
                // Further render_done pulses here are ignored; a frozen boundary is not late.
                if (eof && en) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                state_d = RENDER;
            end
            default: begin
                state_d = INIT;
            end
        endcase

        // Entering SWAP: outputs of the swap cycle are loaded on this edge.
        if (state_d == SWAP) begin
            disp_sel_d     = ~disp_sel_q;
            swap_d         = 1'b1;
            render_start_d = 1'b1;
            consec_clr     = 1'b1;
        end
    end

    // Stall follows the consecutive-late count as it will be after this edge.
    always_comb begin
        stall_d = 1'b0;
        if (!consec_clr) begin
            if (late_inc) begin
                stall_d = (consec >= STALL_PRE);
            end else begin
                stall_d = (consec >= STALL_AT);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= INIT;
            disp_sel_q     <= DISP_A;
            render_start_q <= 1'b0;
            swap_q         <= 1'b0;
            stall_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            disp_sel_q     <= disp_sel_d;
            render_start_q <= render_start_d;
            swap_q         <= swap_d;
            stall_q        <= stall_d;
        end
    end

    // Total late frames since reset; never cleared by a swap.
    sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT (LATE_MAX)
    ) u_late_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (late_inc),
        .clr_i (1'b0),
        .cnt_o (late_cnt)
    );

    // Late frames since the last swap, capped at the stall threshold.
    sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT (LATE_LIMIT)
    ) u_consec_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (late_inc),
        .clr_i (consec_clr),
        .cnt_o (consec)
    );

    assign disp_sel     = disp_sel_q;
    assign render_start = render_start_q;
    assign swap         = swap_q;
    assign stall        = stall_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed scoreboard bench for fb_swap_ctrl: expected outputs queued per stimulus cycle.
// Latency: each vector's expectation is checked after the following rising edge.
// Backpressure: none; the bench drives timing counts directly to frame boundaries.
module tb_fb_swap_ctrl;
    import vga_pkg::*;

    localparam logic [10:0] HE = 11'd1055;
    localparam logic [10:0] VE = 11'd627;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        render_done = 1'b0;
    logic [10:0] hcount = 11'd0;
    logic [10:0] vcount = 11'd0;
    logic        disp_sel;
    logic        render_start;
    logic        swap;
    logic        stall;
    logic [7:0]  late_cnt;

    fb_swap_ctrl #(
        .H_TOTAL    (1056),
        .V_TOTAL    (628),
        .LATE_LIMIT (4),
        .CNT_W      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .hcount       (hcount),
        .vcount       (vcount),
        .render_done  (render_done),
        .disp_sel     (disp_sel),
        .render_start (render_start),
        .swap         (swap),
        .late_cnt     (late_cnt),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rs;
        logic       sw;
        logic       disp;
        logic [7:0] late;
        logic       stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Hand-tracked steady outputs for the directed sequence.
    logic       ed = 1'b0;
    logic [7:0] el = 8'd0;
    logic       es = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // One input vector; outputs are expected after the next rising edge.
    task automatic step(input logic r, input logic e, input logic [10:0] h, input logic [10:0] v,
                        input logic d, input logic xrs, input logic xsw);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; hcount = h; vcount = v; render_done = d;
        x.rs = xrs; x.sw = xsw; x.disp = ed; x.late = el; x.stall = es;
        exp_q.push_back(x);
    endtask

    // Monitor: compare registered outputs just after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                n_vec++;
                chk("render_start", {7'd0, render_start}, {7'd0, x.rs});
                chk("swap",         {7'd0, swap},         {7'd0, x.sw});
                chk("disp_sel",     {7'd0, disp_sel},     {7'd0, x.disp});
                chk("late_cnt",     late_cnt,             x.late);
                chk("stall",        {7'd0, stall},        {7'd0, x.stall});
            end
        end
    end

    // Renderer contract: no render_done while the swap cycle is showing.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(swap && render_done)) else $error("render_done during swap cycle");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 5 cycles: all outputs low.
        repeat (5) step(1'b0, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        // Release: INIT issues a single render_start.
        step(1'b1, 1'b1, 11'd0, 11'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 11'd10, 11'd0, 1'b0, 1'b0, 1'b0);

        // On-time render: done mid-frame, swap at the boundary.
        step(1'b1, 1'b1, 11'd0, 11'd300, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 11'd5, 11'd300, 1'b0, 1'b0, 1'b0);
        ed = 1'b1;
        step(1'b1, 1'b1, HE, VE, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);

        // Done coincident with eof still swaps on that boundary.
        ed = 1'b0;
        step(1'b1, 1'b1, HE, VE, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);

        // Four late frames: late_cnt climbs, stall on the fourth.
        for (int i = 1; i <= 4; i++) begin
            el = 8'(i);
            es = (i >= 4);
            step(1'b1, 1'b1, HE, VE, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 11'd0, 11'd300, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 11'd1, 11'd300, 1'b0, 1'b0, 1'b0);
        ed = 1'b1; es = 1'b0;
        step(1'b1, 1'b1, HE, VE, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);

        // Enable freeze: two boundaries with en=0 neither swap nor count late.
        step(1'b1, 1'b1, 11'd0, 11'd100, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, HE, VE, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 11'd0, 11'd50, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, HE, VE, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        ed = 1'b0;
        step(1'b1, 1'b1, HE, VE, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);

        // Done on eof with en=0 parks in READY; next enabled boundary swaps.
        step(1'b1, 1'b0, HE, VE, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        ed = 1'b1;
        step(1'b1, 1'b1, HE, VE, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 11'd0, 11'd100, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges while READY with disp_sel=1.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_vec++;
        chk("async_disp_sel", {7'd0, disp_sel}, 8'd0);
        chk("async_late_cnt", late_cnt, 8'd0);
        chk("async_stall", {7'd0, stall}, 8'd0);
        ed = 1'b0; el = 8'd0; es = 1'b0;
        step(1'b0, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 11'd0, 11'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 11'd7, 11'd0, 1'b0, 1'b0, 1'b0);

        // Counts beyond the totals never form a boundary.
        step(1'b1, 1'b1, 11'd1100, VE, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, HE, 11'd700, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 11'd2047, 11'd2047, 1'b0, 1'b0, 1'b0);
        el = 8'd1;
        step(1'b1, 1'b1, HE, VE, 1'b0, 1'b0, 1'b0);

        // Extra done pulse in READY is ignored; swap still happens once.
        step(1'b1, 1'b1, 11'd0, 11'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 11'd0, 11'd6, 1'b1, 1'b0, 1'b0);
        ed = 1'b1;
        step(1'b1, 1'b1, HE, VE, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 11'd0, 11'd1, 1'b0, 1'b0, 1'b0);

        // Drain the scoreboard within a fixed budget.
        repeat (3) @(posedge clk);
        #4;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
